// File: rtl/alu_button_cmd.sv
// alu_button_cmd: synchronizes and debounces the add/sub buttons and issues one ALU command per press.
// Optional: define CMD_COUNT_EN to add the cmd_count output (accepted command counter, wraps at 256).
module alu_button_cmd #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int DATA_W          = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] ra1,
  input  logic [DATA_W-1:0] ra2,
  input  logic              add_button,
  input  logic              sub_button,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic              cmd_op,
  output logic [DATA_W-1:0] cmd_a,
  output logic [DATA_W-1:0] cmd_b,
  output logic              busy
`ifdef CMD_COUNT_EN
  ,
  output logic [7:0]        cmd_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    ISSUE,
    HOLD
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_q, op_d;
  logic              add_q1, add_s;
  logic              sub_q1, sub_s;
  logic              sel_s;
  logic              cnt_max;
  logic              hs;
  logic              fire;
  logic              valid_d;
  logic              cop_d;
  logic [DATA_W-1:0] a_d, b_d;

  // Selected button level; op 0 tracks add, op 1 tracks sub.
  assign sel_s   = op_q ? sub_s : add_s;
  assign cnt_max = (cnt_q == CNT_MAX);
  assign hs      = cmd_valid & cmd_ready;
  assign fire    = (state_q == DEBOUNCE) & ~sel_s & cnt_max;
  assign busy    = (state_q != IDLE);

  // Two-flop synchronizers, released level is 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      add_q1 <= 1'b1;
      add_s  <= 1'b1;
      sub_q1 <= 1'b1;
      sub_s  <= 1'b1;
    end else begin
      add_q1 <= add_button;
      add_s  <= add_q1;
      sub_q1 <= sub_button;
      sub_s  <= sub_q1;
    end
  end

  // State, counter, op and command registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_op    <= 1'b0;
      cmd_a     <= '0;
      cmd_b     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      cmd_valid <= valid_d;
      cmd_op    <= cop_d;
      cmd_a     <= a_d;
      cmd_b     <= b_d;
    end
  end

  // Next state and debounce counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      IDLE: begin
        // Exactly one button low; simultaneous presses are dropped.
        if (add_s ^ sub_s) begin
          op_d    = add_s;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (sel_s)
          state_d = IDLE;
        else if (cnt_max)
          state_d = ISSUE;
        else
          cnt_d = cnt_q + CNT_W'(1);
      end
      ISSUE: begin
        if (cmd_ready) begin
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!sel_s)
          cnt_d = '0;
        else if (cnt_max)
          state_d = IDLE;
        else
          cnt_d = cnt_q + CNT_W'(1);
      end
    endcase
  end

  // Command outputs: capture switches on issue, drop valid on handshake.
  always_comb begin
    valid_d = cmd_valid;
    cop_d   = cmd_op;
    a_d     = cmd_a;
    b_d     = cmd_b;
    if (fire) begin
      valid_d = 1'b1;
      cop_d   = op_q;
      a_d     = ra1;
      b_d     = ra2;
    end else if (hs) begin
      valid_d = 1'b0;
    end
  end

`ifdef CMD_COUNT_EN
  // Accepted command counter, wraps naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cmd_count <= 8'd0;
    else if (hs)
      cmd_count <= cmd_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_alu_button_cmd.sv
// tb_alu_button_cmd: directed bench for alu_button_cmd.
// Runs with DEBOUNCE_CYCLES=4; expected values are hand-computed.
module tb_alu_button_cmd;

  logic       clock;
  logic       reset;
  logic [3:0] ra1, ra2;
  logic       add_button, sub_button;
  logic       cmd_ready;
  logic       cmd_valid, cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic       busy;
`ifdef CMD_COUNT_EN
  logic [7:0] cmd_count;
`endif

  int errs;
  int checks;
  int pulses;
  int busy_seen;

  alu_button_cmd #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3),
    .DATA_W(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ra1(ra1),
    .ra2(ra2),
    .add_button(add_button),
    .sub_button(sub_button),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_op(cmd_op),
    .cmd_a(cmd_a),
    .cmd_b(cmd_b),
    .busy(busy)
`ifdef CMD_COUNT_EN
    ,
    .cmd_count(cmd_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_valid"}, 32'(cmd_valid), 0);
    chk({tag, "_op"}, 32'(cmd_op), 0);
    chk({tag, "_a"}, 32'(cmd_a), 0);
    chk({tag, "_b"}, 32'(cmd_b), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    errs       = 0;
    checks     = 0;
    reset      = 1'b1;
    ra1        = 4'd0;
    ra2        = 4'd0;
    add_button = 1'b1;
    sub_button = 1'b1;
    cmd_ready  = 1'b1;
    tick(2);
    outs_zero("rst");
    reset = 1'b0;
    tick(2);

    // 1: clean add press, one pulse after edge 7
    ra1 = 4'd1;
    ra2 = 4'd1;
    add_button = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      chk("t1_valid", 32'(cmd_valid), 32'(i == 7));
      if (i == 3) chk("t1_busy", 32'(busy), 1);
      if (i == 7) begin
        chk("t1_op", 32'(cmd_op), 0);
        chk("t1_a", 32'(cmd_a), 1);
        chk("t1_b", 32'(cmd_b), 1);
      end
    end
    add_button = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      pulses += 32'(cmd_valid);
    end
    chk("t1_nopulse", pulses, 0);
    chk("t1_idle", 32'(busy), 0);

    // 2: bounce shorter than debounce window
    add_button = 1'b0;
    tick(2);
    add_button = 1'b1;
    pulses = 0;
    for (int i = 0; i < 22; i++) begin
      tick(1);
      pulses += 32'(cmd_valid);
    end
    chk("t2_pulses", pulses, 0);
    chk("t2_idle", 32'(busy), 0);

    // 3: both buttons together are ignored
    add_button = 1'b0;
    sub_button = 1'b0;
    pulses = 0;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      pulses += 32'(cmd_valid);
      busy_seen += 32'(busy);
    end
    chk("t3_pulses", pulses, 0);
    chk("t3_busy", busy_seen, 0);
    add_button = 1'b1;
    sub_button = 1'b1;
    tick(4);

    // 4: sub press with back-pressure, switch change ignored
    ra1 = 4'd5;
    ra2 = 4'd3;
    cmd_ready = 1'b0;
    sub_button = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      tick(1);
      chk("t4_valid", 32'(cmd_valid), 32'(i >= 7 && i <= 12));
      if (i >= 7 && i <= 12) begin
        chk("t4_op", 32'(cmd_op), 1);
        chk("t4_a", 32'(cmd_a), 5);
        chk("t4_b", 32'(cmd_b), 3);
      end
      if (i == 8) ra1 = 4'd9;
      if (i == 12) cmd_ready = 1'b1;
    end
    sub_button = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      pulses += 32'(cmd_valid);
    end
    chk("t4_nopulse", pulses, 0);
    chk("t4_idle", 32'(busy), 0);

    // 5: reset during ISSUE, held button re-debounced
    ra1 = 4'd2;
    ra2 = 4'd6;
    cmd_ready = 1'b0;
    add_button = 1'b0;
    tick(7);
    chk("t5_pre", 32'(cmd_valid), 1);
    reset = 1'b1;
    #1;
    outs_zero("t5_rst");
    tick(1);
    reset = 1'b0;
    cmd_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      chk("t5_valid", 32'(cmd_valid), 32'(i == 7));
      if (i == 7) begin
        chk("t5_a", 32'(cmd_a), 2);
        chk("t5_b", 32'(cmd_b), 6);
      end
    end
    add_button = 1'b1;
    tick(10);
    chk("t5_idle", 32'(busy), 0);

`ifdef CMD_COUNT_EN
    // 6: counter wraps after 257 accepted commands
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("t6_zero", 32'(cmd_count), 0);
    for (int n = 0; n < 257; n++) begin
      add_button = 1'b0;
      tick(9);
      add_button = 1'b1;
      tick(8);
    end
    chk("t6_count", 32'(cmd_count), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/alu_button_cmd.md
Name: alu_button_cmd

Overview:
Front-end command source for the ALU board. It conditions the raw active-low add/sub push-buttons with a synchronizer and a debouncer. For each debounced press it issues exactly one ALU command, carrying the operation and the switch operands sampled at issue time. Downstream (ALU datapath) consumes commands through a valid/ready handshake.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles a button must stay stable to count as pressed or released (20 ms at 50 MHz); minimum 2
CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1
DATA_W, 4, operand width (switch bank width)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ra1  input  DATA_W  operand A switches, asynchronous
ra2  input  DATA_W  operand B switches, asynchronous
add_button  input  1  raw add button, active-low, asynchronous
sub_button  input  1  raw sub button, active-low, asynchronous
cmd_ready  input  1  consumer can accept a command
cmd_valid  output  1  command present
cmd_op  output  1  0 = add, 1 = sub
cmd_a  output  DATA_W  operand A
cmd_b  output  DATA_W  operand B
busy  output  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counter 0; synchronizer flops 1 (released).
- Each button passes through a 2-flop synchronizer. Only the synchronized values (add_s, sub_s) are used.
- FSM states and transitions:
  - IDLE: exactly one of add_s/sub_s low -> record op, clear counter, go to DEBOUNCE. Both low in the same cycle -> ignored, stay in IDLE. Add is never given priority.
  - DEBOUNCE: the selected button going high before the count completes -> back to IDLE, nothing issued. Counter reaching DEBOUNCE_CYCLES-1 with the button still low -> on the next edge, register ra1->cmd_a, ra2->cmd_b and op->cmd_op, set cmd_valid=1, go to ISSUE.
  - ISSUE: cmd_valid, cmd_op, cmd_a and cmd_b are held stable until cmd_valid & cmd_ready. Switch changes during this state are not reflected. On the handshake edge, cmd_valid clears and the FSM goes to HOLD with counter cleared.
  - HOLD: the counter increments while the selected button is high and clears whenever it is low. Reaching DEBOUNCE_CYCLES-1 -> IDLE. The other button is ignored in HOLD.
- Latency: counting the first rising edge at or after the raw press as edge 1, cmd_valid is high after edge DEBOUNCE_CYCLES+3, provided the press is stable throughout.
- If cmd_ready is already high when cmd_valid rises, cmd_valid is high for exactly 1 cycle.
- Only one command is issued per press; holding the button produces no repeats.
- Reset mid-operation (any state): immediate return to reset values. Any pending command is discarded, not issued. A button still held after reset deasserts is seen as a new press and is debounced from scratch.
- busy = (state != IDLE).

Optional Feature:
CMD_COUNT_EN
- Defined: adds output cmd_count [7:0], reset 0, incremented on every cmd_valid & cmd_ready edge, wrapping from 255 to 0.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4, cmd_ready=1 unless stated):
1. ra1=1, ra2=1, add_button low for 20 cycles, then high -> one cmd_valid pulse after edge 7 with cmd_op=0, cmd_a=1, cmd_b=1. No second pulse. busy returns to 0 after the release debounce.
2. Bounce: add_button low 2 cycles, high 2 cycles, then high for 20 cycles -> cmd_valid never asserts; FSM returns to IDLE.
3. add_button and sub_button driven low on the same edge, held 20 cycles -> no command issued; busy stays 0.
4. Back-pressure: ra1=5, ra2=3, sub press, cmd_ready=0 for 5 cycles after cmd_valid rises, ra1 changed to 9 during the wait -> cmd_valid held for 6 cycles with cmd_op=1, cmd_a=5, cmd_b=3; single transfer when cmd_ready=1.
5. Reset asserted while in ISSUE (cmd_valid=1, cmd_ready=0) with the button still held -> all outputs 0 immediately. After reset release, a fresh command appears after edge 7.
6. With CMD_COUNT_EN defined: 257 complete add presses -> cmd_count=1.
